// File: rtl/voice_allocator.sv
// ---------------------------------------------------------------------------
// voice_allocator
//
// Polyphonic voice scheduler that sits between the debounced key bank and a
// bank of NUM_VOICES NCOs. On each sample_clk_en strobe it takes a snapshot
// of the keys and runs a multi-cycle scan:
//   RELEASE : one voice per cycle; frees voices whose key is no longer held.
//   PRESS   : one key per cycle, ascending; gives each newly pressed key a
//             voice. It uses the lowest-index free voice first. With the
//             optional feature enabled, it otherwise takes the oldest voice.
//   UPDATE  : one cycle; publishes per-voice increment, mute and key.
// Latency from strobe to scan_done is NUM_VOICES + NUM_KEYS + 2 cycles.
//
// Optional feature (compile-time macro VOICE_STEAL_EN):
//   defined   - when no voice is free, the oldest active voice is stolen.
//               Age counters are 8 bits and saturate.
//   undefined - a press with no free voice is ignored, and no age counters
//               are built.
//
// Ports:
//   clk              system clock
//   rst              asynchronous reset, active low
//   sample_clk_en    one-cycle strobe per audio sample; starts a scan
//   keys             debounced key levels, bit i = key i, 1 = pressed
//   key_increments   packed increment table, slice i = key i
//   voice_increment  packed per-voice NCO increment (0 when the voice is idle)
//   voice_mute       1 = voice silent
//   voice_key        packed key index owned by each voice
//   scan_done        one-cycle pulse when the voice outputs have been updated
//   overrun          sticky; set when a strobe arrives during a scan
//   busy_led         registered OR of the voice active flags
// ---------------------------------------------------------------------------
module voice_allocator #(
    parameter int NUM_KEYS   = 12,
    parameter int NUM_VOICES = 4,
    parameter int INC_W      = 32,
    parameter int KEY_W      = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        sample_clk_en,
    input  logic [NUM_KEYS-1:0]         keys,
    input  logic [NUM_KEYS*INC_W-1:0]   key_increments,
    output logic [NUM_VOICES*INC_W-1:0] voice_increment,
    output logic [NUM_VOICES-1:0]       voice_mute,
    output logic [NUM_VOICES*KEY_W-1:0] voice_key,
    output logic                        scan_done,
    output logic                        overrun,
    output logic                        busy_led
);

    localparam int KEY_SPACE = 2**KEY_W;
    localparam int VOICE_W   = $clog2(NUM_VOICES);
    localparam int CNT_MAX   = (NUM_KEYS > NUM_VOICES) ? NUM_KEYS : NUM_VOICES;
    localparam int IDX_W     = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RELEASE,
        S_PRESS,
        S_UPDATE
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Scan bookkeeping
    logic [IDX_W-1:0]    r_idx;     // voice index in RELEASE, key index in PRESS
    logic [NUM_KEYS-1:0] r_snap;
    logic [NUM_KEYS-1:0] r_new;
    logic [NUM_KEYS-1:0] r_prev;

    // Voice state
    logic [NUM_VOICES-1:0] r_active;
    logic [KEY_W-1:0]      r_key [NUM_VOICES];

    // Output registers
    logic [NUM_VOICES*INC_W-1:0] r_voice_increment;
    logic [NUM_VOICES-1:0]       r_voice_mute;
    logic [NUM_VOICES*KEY_W-1:0] r_voice_key;
    logic                        r_scan_done;
    logic                        r_overrun;
    logic                        r_busy_led;

    // Combinational helpers
    logic [KEY_SPACE-1:0]  w_snap_ext;
    logic [KEY_SPACE-1:0]  w_new_ext;
    logic [INC_W-1:0]      w_inc_tbl [KEY_SPACE];
    logic [KEY_W-1:0]      w_cur_key;
    logic                  w_last_voice;
    logic                  w_last_key;
    logic                  w_scan_start;
    logic [NUM_VOICES-1:0] w_vsel;
    logic [NUM_VOICES-1:0] w_release;
    logic [NUM_VOICES-1:0] w_owns;
    logic                  w_key_owned;
    logic                  w_new_bit;
    logic                  w_free_found;
    logic [VOICE_W-1:0]    w_free_idx;
    logic                  w_steal_found;
    logic [VOICE_W-1:0]    w_steal_idx;
    logic                  w_alloc_do;
    logic [VOICE_W-1:0]    w_alloc_idx;
    logic [NUM_VOICES-1:0] w_alloc_sel;

    // The key vectors are widened to the full key-index space. This lets a
    // KEY_W-bit index select from them directly. The padding bits are never
    // addressed by a real key.
    assign w_snap_ext   = KEY_SPACE'(r_snap);
    assign w_new_ext    = KEY_SPACE'(r_new);
    assign w_cur_key    = KEY_W'(r_idx);
    assign w_last_voice = (r_idx == IDX_W'(NUM_VOICES - 1));
    assign w_last_key   = (r_idx == IDX_W'(NUM_KEYS - 1));
    assign w_scan_start = (r_state == S_IDLE) && sample_clk_en;
    assign w_new_bit    = w_new_ext[w_cur_key];
    assign w_key_owned  = |w_owns;

    // Increment lookup table, padded with zeros up to the full key-index space.
    genvar gi;
    generate
        for (gi = 0; gi < KEY_SPACE; gi++) begin : g_inc_tbl
            if (gi < NUM_KEYS) begin : g_real
                assign w_inc_tbl[gi] = key_increments[gi*INC_W +: INC_W];
            end else begin : g_pad
                assign w_inc_tbl[gi] = '0;
            end
        end
    endgenerate

    // Per-voice decode
    generate
        for (gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
            assign w_vsel[gi]      = (r_idx == IDX_W'(gi));
            assign w_release[gi]   = r_active[gi] && !w_snap_ext[r_key[gi]];
            assign w_owns[gi]      = r_active[gi] && (r_key[gi] == w_cur_key);
            assign w_alloc_sel[gi] = w_alloc_do && (w_alloc_idx == VOICE_W'(gi));
        end
    endgenerate

    // Find the lowest-index inactive voice. The scan runs downward, so the
    // last match written is the lowest index.
    always_comb begin
        w_free_found = 1'b0;
        w_free_idx   = '0;
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (!r_active[i]) begin
                w_free_found = 1'b1;
                w_free_idx   = VOICE_W'(i);
            end
        end
    end

`ifdef VOICE_STEAL_EN
    localparam int AGE_W = 8;

    logic [AGE_W-1:0]      r_age [NUM_VOICES];
    logic [NUM_VOICES-1:0] r_fresh;     // allocated during the current scan
    logic [AGE_W-1:0]      w_best_age;

    // Find the oldest active voice that has not been handed out in this scan.
    // The strict '>' means a tie keeps the lower index.
    always_comb begin
        w_steal_found = 1'b0;
        w_steal_idx   = '0;
        w_best_age    = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (r_active[i] && !r_fresh[i] &&
                (!w_steal_found || (r_age[i] > w_best_age))) begin
                w_steal_found = 1'b1;
                w_steal_idx   = VOICE_W'(i);
                w_best_age    = r_age[i];
            end
        end
    end
`else
    assign w_steal_found = 1'b0;
    assign w_steal_idx   = '0;
`endif

    // A newly pressed key that no voice owns takes a free voice if there is
    // one. Otherwise it takes a stolen voice, when stealing is enabled.
    assign w_alloc_do  = (r_state == S_PRESS) && w_new_bit && !w_key_owned &&
                         (w_free_found || w_steal_found);
    assign w_alloc_idx = w_free_found ? w_free_idx : w_steal_idx;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:    if (sample_clk_en) w_state_next = S_RELEASE;
            S_RELEASE: if (w_last_voice)  w_state_next = S_PRESS;
            S_PRESS:   if (w_last_key)    w_state_next = S_UPDATE;
            S_UPDATE:  w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    // ---------------- Scan control ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_idx       <= '0;
            r_snap      <= '0;
            r_new       <= '0;
            r_prev      <= '0;
            r_scan_done <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_scan_done <= (r_state == S_UPDATE);
            // A strobe that arrives mid-scan is dropped. The event is recorded.
            if (sample_clk_en && (r_state != S_IDLE)) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (sample_clk_en) begin
                        r_snap <= keys;
                        r_new  <= keys & ~r_prev;
                        r_idx  <= '0;
                    end
                end
                S_RELEASE: r_idx  <= w_last_voice ? '0 : r_idx + 1'b1;
                S_PRESS:   r_idx  <= r_idx + 1'b1;
                S_UPDATE:  r_prev <= r_snap;
                default:   ;
            endcase
        end
    end

    // ---------------- Voice state ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_active <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                r_key[i] <= '0;
`ifdef VOICE_STEAL_EN
                r_age[i] <= '0;
`endif
            end
`ifdef VOICE_STEAL_EN
            r_fresh <= '0;
`endif
        end else begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                // The key index is kept after release, so voice_key still
                // shows the last key that the voice played.
                if ((r_state == S_RELEASE) && w_vsel[i] && w_release[i]) begin
                    r_active[i] <= 1'b0;
`ifdef VOICE_STEAL_EN
                    r_age[i]    <= '0;
`endif
                end
                if (w_alloc_sel[i]) begin
                    r_active[i] <= 1'b1;
                    r_key[i]    <= w_cur_key;
`ifdef VOICE_STEAL_EN
                    r_age[i]    <= '0;
                    r_fresh[i]  <= 1'b1;
                end else if (w_alloc_do && r_active[i] &&
                             (r_age[i] != {AGE_W{1'b1}})) begin
                    r_age[i]    <= r_age[i] + 1'b1;
`endif
                end
`ifdef VOICE_STEAL_EN
                if (w_scan_start) begin
                    r_fresh[i] <= 1'b0;
                end
`endif
            end
        end
    end

    // ---------------- Published outputs (change only in UPDATE) ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_voice_increment <= '0;
            r_voice_mute      <= '1;
            r_voice_key       <= '0;
            r_busy_led        <= 1'b0;
        end else if (r_state == S_UPDATE) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                r_voice_increment[i*INC_W +: INC_W] <= r_active[i] ? w_inc_tbl[r_key[i]] : '0;
                r_voice_key[i*KEY_W +: KEY_W]       <= r_key[i];
            end
            r_voice_mute <= ~r_active;
            r_busy_led   <= |r_active;
        end
    end

    assign voice_increment = r_voice_increment;
    assign voice_mute      = r_voice_mute;
    assign voice_key       = r_voice_key;
    assign scan_done       = r_scan_done;
    assign overrun         = r_overrun;
    assign busy_led        = r_busy_led;

endmodule
